// File: rtl/pipe_adder.sv
// pipe_adder: chunked, pipelined add/subtract with a global valid/ready stall
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_ovf
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  logic             w_adv;
  logic [WIDTH-1:0] w_a [STAGES];
  logic [WIDTH-1:0] w_b [STAGES];
  logic [WIDTH-1:0] w_s [STAGES];
  logic             w_ci [STAGES];
  logic             w_v [STAGES];
  logic [CHUNK:0]   w_sum [STAGES];
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_v [STAGES];
  logic             r_o;
  assign w_adv       = !o_out_valid || i_out_ready;
  assign o_in_ready  = w_adv;
  assign o_out_valid = r_v[L];
  assign o_s         = r_s[L];
  assign o_cout      = r_c[L];
  assign o_ovf       = r_o;
  // stage inputs (operands skewed, lower result chunks deskewed) and one chunk add per stage
  always_comb begin
    w_a[0]  = i_a;
    w_b[0]  = i_sub ? ~i_b : i_b;
    w_s[0]  = '0;
    w_ci[0] = i_sub ^ i_cin;
    w_v[0]  = i_in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_a[k]  = r_a[k-1];
      w_b[k]  = r_b[k-1];
      w_s[k]  = r_s[k-1];
      w_ci[k] = r_c[k-1];
      w_v[k]  = r_v[k-1];
    end
    for (int k = 0; k < STAGES; k++)
      w_sum[k] = {1'b0, w_a[k][k*CHUNK +: CHUNK]} + {1'b0, w_b[k][k*CHUNK +: CHUNK]} + (CHUNK+1)'(w_ci[k]);
  end
  // whole pipe shifts together on advance; the last stage doubles as the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
      r_o <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= w_a[k];
        r_b[k] <= w_b[k];
        r_s[k] <= w_s[k] | (WIDTH'(w_sum[k][CHUNK-1:0]) << (k * CHUNK));
        r_c[k] <= w_sum[k][CHUNK];
        r_v[k] <= w_v[k];
      end
      r_o <= (w_a[L][WIDTH-1] == w_b[L][WIDTH-1]) && (w_sum[L][CHUNK-1] != w_a[L][WIDTH-1]);
    end
  end
endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined adder/subtractor with valid/ready handshake. Splits a WIDTH-bit operand pair into STAGES equal chunks. Each pipeline stage adds one chunk, LSB chunk first, and forwards the carry to the next stage, so clock frequency scales with chunk width rather than full width. Sits between operand producers and datapath consumers wherever a registered, throttleable multi-bit add is needed.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of STAGES
- STAGES, 4, pipeline depth and number of chunks; CHUNK = WIDTH/STAGES; STAGES=1 is legal
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand set present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- s  output  WIDTH  sum/difference
- cout  output  1  carry-out; in subtract mode, 1 = no borrow
- ovf  output  1  two's-complement signed overflow

## Operation
- Effective operands: bx = sub ? ~b : b; c0 = sub ? ~cin : cin.
- Result: {cout,s} = a + bx + c0. Add mode gives a+b+cin; subtract mode gives a-b-cin.
- ovf = (a[MSB] == bx[MSB]) && (s[MSB] != a[MSB]).
- Stage k (0..STAGES-1):
  - Adds chunk k of a and chunk k of bx with the carry registered from stage k-1 (c0 for stage 0).
  - Registers the CHUNK-bit partial sum and its carry.
- Skew and deskew: operand chunks for higher stages pass through input skew registers. Already-computed lower result chunks pass through output deskew registers. All chunks of one transaction leave together.
- Sign bits a[MSB] and bx[MSB] travel alongside the data to compute ovf in the last stage.
- Each stage holds a valid bit.
- Global advance: adv = !out_valid || out_ready. in_ready = adv.
- When adv=1:
  - Every stage shifts forward.
  - Stage 0 loads in_valid and the operands.
  - The last stage loads out_valid, s, cout and ovf.
- When adv=0: all registers, including outputs, hold.
- Bubbles are not collapsed; an empty stage travels like data.
- Transactions complete in acceptance order. No drops, no duplicates.
- Operand values on cycles with in_valid=0 are don't-care and never produce out_valid.

## Timing
- Reset (rst_n low, asynchronous):
  - All stage valid bits = 0, all data registers = 0.
  - out_valid = 0, s = 0, cout = 0, ovf = 0, in_ready = 1.
- Reset mid-operation flushes every in-flight transaction. No stale result appears after rst_n rises.
- Accept: a transaction is accepted on a rising edge where in_valid && in_ready.
- Latency: the result is visible with out_valid=1 exactly STAGES cycles after the accepting edge when no stall occurs (STAGES=1: next cycle).
- Throughput: one result per cycle while out_ready stays high.
- Stall: while out_valid && !out_ready:
  - s, cout, ovf and out_valid are stable.
  - in_ready = 0.
  - Internal stages do not advance.
- A result is consumed on an edge where out_valid && out_ready. A new input may be accepted on the same edge.
- in_ready depends combinationally on out_ready and registered out_valid only; there is no path from in_valid.
- Carry across a chunk boundary takes exactly one stage. Full-width carry propagation, e.g. 0xFFFF+1, needs no extra cycles.

## Test plan
All scenarios use WIDTH=16, STAGES=4 unless noted.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0, sub=0 → 4 cycles later s=0x0000, cout=1, ovf=0.
- Signed overflow, add: a=0x7FFF, b=0x0001, sub=0 → s=0x8000, cout=0, ovf=1.
- Subtract, borrow: a=0x0005, b=0x0007, cin=0, sub=1 → s=0xFFFE, cout=0, ovf=0.
- Subtract, overflow: a=0x8000, b=0x0001, sub=1 → s=0x7FFF, cout=1, ovf=1.
- Subtract with borrow-in: a=0x0010, b=0x0001, cin=1, sub=1 → s=0x000E, cout=1.
- Streaming: 8 back-to-back ops with out_ready=1 → results appear in order on 8 consecutive cycles, the first 4 cycles after the first accept.
- Backpressure: drop out_ready for 3 cycles while out_valid=1 → s/cout/ovf held, in_ready=0 for those cycles, no loss or duplication. The remaining results resume in order after release.
- Reset mid-stream: assert rst_n low with 3 ops in flight → out_valid=0 and s=0 immediately. After release, no out_valid until a new op is accepted and STAGES cycles pass.
- STAGES=1, WIDTH=8: a=0xFF, b=0x01 → s=0x00, cout=1 one cycle after accept. Repeat the random-compare run against a reference model (a+bx+c0) over 10k random ops with random out_ready.
